// File: rtl/parking_session_ctrl.sv
// Parking bay session controller: debounces the bay sensor, drives the
// external second counter, bills the stay, collects payment and releases
// the gate. All outputs come straight from flops.
module parking_session_ctrl #(
    parameter int unsigned DEBOUNCE  = 3,
    parameter int unsigned GRACE_SEC = 10,
    parameter int unsigned MAX_SEC   = 3600
) (
    input  logic        clk_1Hz,
    input  logic        rst,
    input  logic        car_present,
    input  logic [11:0] sec_count,
    input  logic        pay_valid,
    input  logic [7:0]  pay_amt,
    output logic        parked,
    output logic        cnt_clr,
    output logic [7:0]  fee,
    output logic [7:0]  paid,
    output logic [7:0]  change,
    output logic        gate_open,
    output logic        overtime,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        PARKED = 3'd2,
        BILL   = 3'd3,
        PAY    = 3'd4,
        EXIT   = 3'd5
    } state_t;

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    // Kept as a raw 3-bit register so the unused codes 6/7 are representable
    // and recover through the default branch.
    logic [2:0]  cur;
    state_t      nxt;
    logic [3:0]  dcnt;
    logic [3:0]  dcnt_nxt;
    logic [12:0] rounded;
    logic [7:0]  fee_calc;
    logic [8:0]  pay_sum;

    assign state = cur;

    // Fee from elapsed seconds: grace period free, otherwise ceil(s/16) capped at 255.
    always_comb begin
        rounded  = ({1'b0, sec_count} + 13'd15) >> 4;
        fee_calc = '0;
        if (32'(sec_count) >= GRACE_SEC)
            fee_calc = (rounded > 13'd255) ? 8'hFF : rounded[7:0];
        pay_sum = {1'b0, paid} + {1'b0, pay_amt};
    end

    // Next state and debounce count; the count restarts on every state change.
    always_comb begin
        nxt      = IDLE;
        dcnt_nxt = '0;
        case (cur)
            IDLE: begin
                if (car_present) begin
                    if (dcnt == DB_LAST) nxt = ARM;
                    else dcnt_nxt = dcnt + 4'd1;
                end
            end
            ARM: nxt = PARKED;
            PARKED: begin
                nxt = PARKED;
                if (!car_present) begin
                    if (dcnt == DB_LAST) nxt = BILL;
                    else dcnt_nxt = dcnt + 4'd1;
                end
            end
            BILL: nxt = (fee_calc == 8'd0) ? EXIT : PAY;
            PAY:  nxt = (paid >= fee) ? EXIT : PAY;
            EXIT: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // State, counter and registered outputs; pulse outputs are decoded from
    // the next state so they line up with the state they belong to.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            cur       <= IDLE;
            dcnt      <= '0;
            parked    <= 1'b0;
            cnt_clr   <= 1'b0;
            gate_open <= 1'b0;
            overtime  <= 1'b0;
            fee       <= '0;
            paid      <= '0;
            change    <= '0;
        end else begin
            cur       <= nxt;
            dcnt      <= dcnt_nxt;
            parked    <= (nxt == PARKED);
            cnt_clr   <= (nxt == ARM);
            gate_open <= (nxt == EXIT);

            if (cur == IDLE && nxt == ARM) begin
                fee    <= '0;
                paid   <= '0;
                change <= '0;
            end

            if (cur == PARKED && 32'(sec_count) >= MAX_SEC)
                overtime <= 1'b1;
            else if (cur != IDLE && nxt == IDLE)
                overtime <= 1'b0;

            if (cur == BILL)
                fee <= fee_calc;

            if (cur == PAY && nxt == PAY && pay_valid)
                paid <= pay_sum[8] ? 8'hFF : pay_sum[7:0];

            if (cur == PAY && nxt == EXIT)
                change <= paid - fee;
        end
    end

endmodule

// File: tb/tb_parking_session_ctrl.sv
// Bench for parking_session_ctrl: directed session scenarios with literal
// expectations, then randomized sessions checked every cycle against a
// session-level reference model.
module tb_parking_session_ctrl;

    localparam int DB    = 3;
    localparam int GRACE = 10;
    localparam int MAXS  = 3600;

    logic        clk_1Hz = 1'b0;
    logic        rst = 1'b1;
    logic        car_present = 1'b0;
    logic [11:0] sec_count = '0;
    logic        pay_valid = 1'b0;
    logic [7:0]  pay_amt = '0;
    logic        parked, cnt_clr, gate_open, overtime;
    logic [7:0]  fee, paid, change;
    logic [2:0]  state;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: session phase (spec encodings), run length of the
    // awaited sensor level, and session money.
    int m_st = 0, m_run = 0, m_fee = 0, m_paid = 0, m_change = 0, m_ovt = 0;

    parking_session_ctrl #(.DEBOUNCE(DB), .GRACE_SEC(GRACE), .MAX_SEC(MAXS)) dut (
        .clk_1Hz(clk_1Hz), .rst(rst), .car_present(car_present),
        .sec_count(sec_count), .pay_valid(pay_valid), .pay_amt(pay_amt),
        .parked(parked), .cnt_clr(cnt_clr), .fee(fee), .paid(paid),
        .change(change), .gate_open(gate_open), .overtime(overtime),
        .state(state)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int fee_of(input int s);
        int f;
        if (s < GRACE) return 0;
        f = (s + 15) / 16;
        return (f > 255) ? 255 : f;
    endfunction

    task automatic model_reset();
        m_st = 0; m_run = 0; m_fee = 0; m_paid = 0; m_change = 0; m_ovt = 0;
    endtask

    task automatic go(input int n);
        m_st = n;
        m_run = 0;
    endtask

    // One second of session behaviour, described by the rules of each phase.
    task automatic model_step();
        int s;
        s = int'(sec_count);
        case (m_st)
            0: begin
                m_run = car_present ? m_run + 1 : 0;
                if (m_run == DB) begin
                    m_fee = 0; m_paid = 0; m_change = 0;
                    go(1);
                end
            end
            1: go(2);
            2: begin
                if (s >= MAXS) m_ovt = 1;
                m_run = !car_present ? m_run + 1 : 0;
                if (m_run == DB) go(3);
            end
            3: begin
                m_fee = fee_of(s);
                if (m_fee == 0) begin
                    m_change = 0;
                    go(5);
                end else go(4);
            end
            4: begin
                if (m_paid >= m_fee) begin
                    m_change = m_paid - m_fee;
                    go(5);
                end else if (pay_valid) begin
                    m_paid = m_paid + int'(pay_amt);
                    if (m_paid > 255) m_paid = 255;
                end
            end
            default: begin
                m_ovt = 0;
                go(0);
            end
        endcase
    endtask

    task automatic cycle();
        @(posedge clk_1Hz);
        if (!rst) model_step();
        #2;
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_1Hz) begin
        chk("state", int'(state), m_st);
        chk("parked", int'(parked), (m_st == 2) ? 1 : 0);
        chk("cnt_clr", int'(cnt_clr), (m_st == 1) ? 1 : 0);
        chk("gate_open", int'(gate_open), (m_st == 5) ? 1 : 0);
        chk("overtime", int'(overtime), m_ovt);
        chk("fee", int'(fee), m_fee);
        chk("paid", int'(paid), m_paid);
        chk("change", int'(change), m_change);
    end

    task automatic arrive();
        car_present = 1'b1;
        repeat (DB) cycle();
        chk("arm_state", int'(state), 1);
        chk("arm_cnt_clr", int'(cnt_clr), 1);
        cycle();
        chk("parked_state", int'(state), 2);
        chk("parked_out", int'(parked), 1);
        chk("cnt_clr_once", int'(cnt_clr), 0);
    endtask

    task automatic depart();
        car_present = 1'b0;
        repeat (DB) cycle();
        chk("bill_state", int'(state), 3);
        chk("bill_parked", int'(parked), 0);
    endtask

    task automatic pay(input int amt);
        pay_valid = 1'b1;
        pay_amt = 8'(amt);
        cycle();
        pay_valid = 1'b0;
    endtask

    int picks[8] = '{0, 8, 9, 10, 100, 3599, 3600, 4095};

    initial begin
        // Reset held for 10 cycles.
        repeat (10) cycle();
        chk("rst_state", int'(state), 0);
        chk("rst_fee", int'(fee), 0);
        rst = 1'b0;

        // Arrival and glitch rejection.
        arrive();
        car_present = 1'b0;
        repeat (2) cycle();
        car_present = 1'b1;
        repeat (2) cycle();
        chk("glitch_state", int'(state), 2);
        chk("glitch_parked", int'(parked), 1);

        // Paid session: 100 s -> fee 7, pay 5+5.
        sec_count = 12'd100;
        depart();
        cycle();
        chk("fee_100", int'(fee), 7);
        chk("pay_state", int'(state), 4);
        pay(5);
        chk("paid_5", int'(paid), 5);
        pay(5);
        chk("paid_10", int'(paid), 10);
        cycle();
        chk("exit_state", int'(state), 5);
        chk("exit_gate", int'(gate_open), 1);
        chk("change_3", int'(change), 3);
        cycle();
        chk("back_idle", int'(state), 0);
        chk("change_held", int'(change), 3);

        // Grace session: 8 s -> free exit.
        sec_count = 12'd8;
        arrive();
        depart();
        cycle();
        chk("grace_exit", int'(state), 5);
        chk("grace_fee", int'(fee), 0);
        chk("grace_gate", int'(gate_open), 1);
        chk("grace_change", int'(change), 0);
        cycle();

        // Overtime and saturation.
        sec_count = 12'd0;
        arrive();
        sec_count = 12'd3600;
        cycle();
        chk("ovt_set", int'(overtime), 1);
        sec_count = 12'd4095;
        depart();
        cycle();
        chk("fee_4095", int'(fee), 255);
        chk("ovt_in_pay", int'(overtime), 1);
        pay(200);
        pay(200);
        chk("paid_sat", int'(paid), 255);
        cycle();
        chk("sat_change", int'(change), 0);
        cycle();
        chk("ovt_clear", int'(overtime), 0);

        // Reset during PAY.
        sec_count = 12'd50;
        arrive();
        depart();
        cycle();
        chk("fee_50", int'(fee), 4);
        pay(4);
        chk("paid_4", int'(paid), 4);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_paid", int'(paid), 0);
        chk("mid_rst_fee", int'(fee), 0);
        model_reset();
        repeat (2) cycle();
        rst = 1'b0;
        car_present = 1'b0;
        pay_valid = 1'b1;
        pay_amt = 8'd9;
        repeat (3) cycle();
        pay_valid = 1'b0;
        chk("idle_ignores_pay", int'(paid), 0);

        // Randomized sessions.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            case (m_st)
                0: begin
                    car_present = ($urandom_range(0, 9) < 7);
                    sec_count = ($urandom_range(0, 1) == 0) ? 12'(picks[$urandom_range(0, 7)])
                                                            : 12'($urandom_range(0, 4095));
                end
                2: begin
                    car_present = ($urandom_range(0, 9) < 7);
                    if ($urandom_range(0, 49) == 0)
                        sec_count = 12'($urandom_range(int'(sec_count), 4095));
                end
                default: car_present = 1'($urandom_range(0, 1));
            endcase
            pay_valid = ($urandom_range(0, 3) == 0);
            pay_amt = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 10));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_session_ctrl.md
PARKING_SESSION_CTRL -- requirements
Module: parking_session_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE, default 3, meaning the number of consecutive cycles car_present must hold a new level before it is accepted (legal range 1..15).
REQ-002 SHALL have parameter GRACE_SEC, default 10, meaning sessions shorter than this many seconds are billed 0.
REQ-003 SHALL have parameter MAX_SEC, default 3600, meaning the session length in seconds at which overtime is flagged.
REQ-004 SHALL have port clk_1Hz, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port car_present, input, 1 bit: raw bay sensor, synchronous to clk_1Hz.
REQ-007 SHALL have port sec_count, input, 12 bits: elapsed-seconds value from the second counter.
REQ-008 SHALL have port pay_valid, input, 1 bit: one-cycle payment strobe.
REQ-009 SHALL have port pay_amt, input, 8 bits: payment units, valid when pay_valid=1.
REQ-010 SHALL have port parked, output, 1 bit: count enable driven to the second counter.
REQ-011 SHALL have port cnt_clr, output, 1 bit: one-cycle clear pulse driven to the second counter.
REQ-012 SHALL have port fee, output, 8 bits: latched session fee.
REQ-013 SHALL have port paid, output, 8 bits: accumulated payment.
REQ-014 SHALL have port change, output, 8 bits: paid minus fee, latched on exit.
REQ-015 SHALL have port gate_open, output, 1 bit: one-cycle release pulse.
REQ-016 SHALL have port overtime, output, 1 bit: session has exceeded MAX_SEC.
REQ-017 SHALL have port state, output, 3 bits: current FSM state encoding.

Function
REQ-018 SHALL implement FSM states with these encodings: IDLE=0, ARM=1, PARKED=2, BILL=3, PAY=4, EXIT=5; codes 6 and 7 SHALL return to IDLE on the next cycle.
REQ-019 SHALL register every output, with no combinational path from an input to an output.
REQ-020 SHALL, in IDLE, count consecutive cycles with car_present=1, clear the count on any 0, and move to ARM on the cycle the count reaches DEBOUNCE.
REQ-021 SHALL, in ARM, assert cnt_clr for exactly one cycle with parked=0, clear fee, paid and change to 0, and move to PARKED.
REQ-022 SHALL, in PARKED, hold parked=1 and move to BILL after DEBOUNCE consecutive cycles with car_present=0; glitches shorter than DEBOUNCE SHALL be ignored.
REQ-023 SHALL set overtime to 1 while in PARKED with sec_count>=MAX_SEC, hold it through PAY, and clear it on entry to IDLE.
REQ-024 SHALL, in BILL, drop parked to 0, latch the fee from sec_count, and spend one cycle in that state.
REQ-025 SHALL compute the fee as follows: 0 if sec_count<GRACE_SEC, otherwise ceil(sec_count/16) saturated to 255 (sec_count=4095 gives 255).
REQ-026 SHALL leave BILL for EXIT if fee==0, otherwise for PAY.
REQ-027 SHALL, in PAY, add pay_amt to paid on each pay_valid, saturating at 255, and move to EXIT on the cycle after the update that makes paid>=fee.
REQ-028 SHALL ignore pay_valid in every state except PAY.
REQ-029 SHALL ignore car_present while in PAY, so the session remains unpaid until settled.
REQ-030 SHALL, in EXIT, pulse gate_open for one cycle, latch change=paid-fee, and return to IDLE.
REQ-031 SHALL reset the debounce counter on every state change.
REQ-032 SHALL hold fee, paid and change at their values in IDLE until the next ARM.

Reset
REQ-033 SHALL, while rst=1, force state=IDLE, parked=0, cnt_clr=0, gate_open=0, overtime=0, fee=0, paid=0, change=0, and the debounce count to 0, asynchronously.
REQ-034 SHALL, on rst asserted mid-session in any state, abandon the session, so that the next session requires a fresh debounce.

Verification
REQ-035 SHALL cover this scenario: rst for 10 cycles, then car_present=1 for 3 cycles -> state goes 0->1->2, cnt_clr pulses once, and parked=1.
REQ-036 SHALL cover this scenario: while PARKED, car_present drops for 2 cycles then returns -> parked stays 1 and no BILL occurs.
REQ-037 SHALL cover this scenario: depart with sec_count=100 -> fee=7 and PAY is entered; pay 5 then pay 5 -> paid=10, gate_open pulses, change=3, and state returns to IDLE.
REQ-038 SHALL cover this scenario: depart with sec_count=8 (below GRACE_SEC) -> fee=0, BILL goes to EXIT, gate_open pulses with no payment, and change=0.
REQ-039 SHALL cover this scenario: sec_count reaches 3600 while PARKED -> overtime=1 and stays 1 through PAY; fee for 4095 is 255; paying 200 then 200 -> paid=255 and change=0.
REQ-040 SHALL cover this scenario: rst pulsed during PAY with paid=4 -> every output reads 0 immediately, and pay_valid is ignored in IDLE.
